obw_reg_bus: RTL and testbench

- Parametrised successor to the single-bit tristate output buffer with weak keeper.
- Drives a WIDTH-bit output bus from a clock-enabled output data register.
- Output enable is sequenced by a turnaround state machine with a request/acknowledge handshake, enforcing break-before-make high-Z gaps.
- Honours the global tristate net and holds a released bus with a per-bit weak keeper; used for shared board buses and bidirectional-pin wrappers.

---
 rtl/obw_reg_bus.sv | 123 ++++++++++++
 tb/tb_obw_reg_bus.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/obw_reg_bus.sv
// obw_reg_bus: registered WIDTH-bit tristate bus driver with break-before-make turnaround.
// Define OBW_BUS_KEEPER_EN to add a per-bit weak keeper on the released bus.
module obw_reg_bus #(
   parameter int unsigned     WIDTH       = 8,
   parameter int unsigned     TURN_CYCLES = 2,
   parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] I,
   input  logic             CE,
   input  logic             OE_REQ,
   output logic             OE_ACK,
   output logic             BUSY,
   output tri   [WIDTH-1:0] O
);

   localparam int unsigned   CW        = $clog2(TURN_CYCLES + 1);
   localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE_Z,
      TURN_ON,
      DRIVE,
      TURN_OFF
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             tsall;
   logic             drv_en;

   // Global tristate net; reads 0 unless something upstream drives it.
   if (1) begin : TSALL_INST
      tri0 TSALLNET;
   end

   assign tsall = TSALL_INST.TSALLNET;

   always_comb begin
      q_d = q_q;
      if (CE) begin
         q_d = I;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE_Z: begin
            if (OE_REQ) begin
               state_d = TURN_ON;
               cnt_d   = TURN_LOAD;
            end
         end
         TURN_ON: begin
            if (!OE_REQ) begin
               state_d = IDLE_Z;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DRIVE: begin
            if (!OE_REQ) begin
               state_d = TURN_OFF;
               cnt_d   = TURN_LOAD;
            end
         end
         TURN_OFF: begin
            // Request is deliberately ignored until the gap completes.
            if (cnt_q == '0) begin
               state_d = IDLE_Z;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE_Z;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE_Z;
         cnt_q   <= '0;
         q_q     <= INIT_VAL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign OE_ACK = (state_q == DRIVE);
   assign BUSY   = (state_q == TURN_ON) || (state_q == TURN_OFF);
   assign drv_en = (state_q == DRIVE) && !tsall;

   assign O = drv_en ? q_q : {WIDTH{1'bz}};

`ifdef OBW_BUS_KEEPER_EN
   // Keeper remembers the last resolved level; not cleared by reset.
   for (genvar b = 0; b < WIDTH; b++) begin : g_keep
      logic keep_q;
      always @(O[b]) begin
         if (O[b] === 1'b0) begin
            keep_q <= 1'b0;
         end else if (O[b] === 1'b1) begin
            keep_q <= 1'b1;
         end
      end
      assign (weak0, weak1) O[b] = keep_q;
   end
`else
`endif

endmodule

// File: tb/tb_obw_reg_bus.sv
// Testbench for obw_reg_bus: table vectors plus hand sequences, scoreboard compare.
// Bus has a pull-up, so a released bus reads 8'hFF.
module tb_obw_reg_bus;

   localparam logic [7:0] REL = 8'hFF;

   logic       clk = 1'b0;
   logic       rst;
   logic       ce;
   logic       oe_req;
   logic [7:0] din;
   logic       oe_ack;
   logic       busy;
   tri1  [7:0] o_bus;

   always #5 clk = ~clk;

   obw_reg_bus #(
      .WIDTH(8),
      .TURN_CYCLES(2),
      .INIT_VAL(8'h00)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .I(din),
      .CE(ce),
      .OE_REQ(oe_req),
      .OE_ACK(oe_ack),
      .BUSY(busy),
      .O(o_bus)
   );

   typedef struct {
      string      name;
      logic       ack;
      logic       busy;
      logic [7:0] o;
   } exp_t;

   typedef struct {
      logic       req;
      logic       ce;
      logic [7:0] i;
      logic       ack;
      logic       busy;
      logic [7:0] o;
   } vec_t;

   exp_t sb[$];
   vec_t vt[22];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic check(string name, logic [7:0] got, logic [7:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, want);
   endtask

   task automatic push(string name, logic ack, logic b, logic [7:0] o);
      exp_t e;
      e.name = name;
      e.ack  = ack;
      e.busy = b;
      e.o    = o;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      check({e.name, ".ack"}, {7'd0, oe_ack}, {7'd0, e.ack});
      check({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
      check({e.name, ".o"}, o_bus, e.o);
   endtask

   task automatic step(string name, logic req, logic c, logic [7:0] d,
                       logic ack, logic b, logic [7:0] o);
      oe_req = req;
      ce     = c;
      din    = d;
      push(name, ack, b, o);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // req ce  i      ack busy o
      vt[0]  = '{1, 0, 8'h00, 0, 1, REL};   // edge 0: TURN_ON
      vt[1]  = '{1, 0, 8'h00, 0, 1, REL};   // edge 1
      vt[2]  = '{1, 0, 8'h00, 1, 0, 8'h00}; // edge 2: DRIVE with INIT
      vt[3]  = '{1, 1, 8'hA5, 1, 0, 8'hA5};
      vt[4]  = '{1, 0, 8'h3C, 1, 0, 8'hA5};
      vt[5]  = '{0, 0, 8'h00, 0, 1, REL};   // m: TURN_OFF
      vt[6]  = '{1, 0, 8'h00, 0, 1, REL};   // m+1 ignored
      vt[7]  = '{1, 0, 8'h00, 0, 0, REL};   // m+2 IDLE_Z
      vt[8]  = '{1, 0, 8'h00, 0, 1, REL};   // m+3 TURN_ON
      vt[9]  = '{1, 0, 8'h00, 0, 1, REL};
      vt[10] = '{1, 0, 8'h00, 1, 0, 8'hA5}; // m+5 DRIVE
      vt[11] = '{1, 1, 8'hFF, 1, 0, 8'hFF};
      vt[12] = '{0, 0, 8'h00, 0, 1, REL};
      vt[13] = '{0, 0, 8'h00, 0, 1, REL};
      vt[14] = '{0, 0, 8'h00, 0, 0, REL};
      vt[15] = '{1, 0, 8'h00, 0, 1, REL};   // abort
      vt[16] = '{0, 0, 8'h00, 0, 0, REL};
      vt[17] = '{0, 0, 8'h00, 0, 0, REL};
      vt[18] = '{1, 1, 8'h3C, 0, 1, REL};   // load during TURN_ON
      vt[19] = '{1, 1, 8'h5A, 0, 1, REL};
      vt[20] = '{1, 0, 8'h00, 1, 0, 8'h5A};
      vt[21] = '{1, 1, 8'hC3, 1, 0, 8'hC3};

      rst    = 1'b1;
      ce     = 1'b0;
      oe_req = 1'b0;
      din    = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      push("reset", 0, 0, REL);
      compare_out();
      rst = 1'b0;

      for (int k = 0; k < 22; k++) begin
         step($sformatf("vec%0d", k), vt[k].req, vt[k].ce, vt[k].i,
              vt[k].ack, vt[k].busy, vt[k].o);
      end

      step("ts_load", 1, 1, 8'hA5, 1, 0, 8'hA5);
      force dut.tsall = 1'b1;
      #1;
      push("ts_on", 1, 0, REL);
      compare_out();
      step("ts_hold", 1, 1, 8'h3C, 1, 0, REL);
      release dut.tsall;
      #1;
      push("ts_off", 1, 0, 8'h3C);
      compare_out();

      step("ar_ff", 1, 1, 8'hFF, 1, 0, 8'hFF);
      #3 rst = 1'b1;
      #1;
      push("ar_now", 0, 0, REL);
      compare_out();
      oe_req = 1'b0;
      ce     = 1'b0;
      #1 rst = 1'b0;
      step("ar_on0", 1, 0, 8'h77, 0, 1, REL);
      step("ar_on1", 1, 0, 8'h77, 0, 1, REL);
      step("ar_init", 1, 0, 8'h77, 1, 0, 8'h00);

      step("rt_off0", 0, 0, 8'h00, 0, 1, REL);
      step("rt_off1", 0, 0, 8'h00, 0, 1, REL);
      step("rt_idle", 0, 0, 8'h00, 0, 0, REL);
      step("rt_on", 1, 0, 8'h00, 0, 1, REL);
      #3 rst = 1'b1;
      #1;
      push("rt_now", 0, 0, REL);
      compare_out();
      step("rt_held", 1, 0, 8'h00, 0, 0, REL);
      rst = 1'b0;
      step("rt_on0", 1, 0, 8'h00, 0, 1, REL);
      step("rt_on1", 1, 0, 8'h00, 0, 1, REL);
      step("rt_drv", 1, 1, 8'h5A, 1, 0, 8'h5A);
      #3 rst = 1'b1;
      #1;
      push("rd_now", 0, 0, REL);
      compare_out();
      oe_req = 1'b0;
      #1 rst = 1'b0;
      step("rd_idle", 0, 0, 8'h00, 0, 0, REL);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
